mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, fed by the register file's two read ports (rs, rt) and holding the architectural HI/LO registers. It executes mult/multu/div/divu over 33 cycles with a start/busy/done handshake. HI/LO are read back by mfhi/mflo, whose results go to the register file write port, and are written directly by mthi/mtlo.

## Interface
- Parameters: none (datapath fixed at 32 bits, matching register file width).
- clock  input  1  rising-edge clock shared with the register file.
- reset  input  1  synchronous, active-high; sampled on rising edge of `clock`.
- start  input  1  request a new operation; accepted only in IDLE.
- op  input  2  operation code:
  - 00 multu
  - 01 mult
  - 10 divu
  - 11 div
- operand_a  input  32  rs value (multiplicand / dividend); sampled on the accepting edge.
- operand_b  input  32  rt value (multiplier / divisor); sampled on the accepting edge.
- hi_write  input  1  mthi: load `write_data` into HI.
- lo_write  input  1  mtlo: load `write_data` into LO.
- write_data  input  32  data for mthi/mtlo.
- busy  output  1  high while an operation is in flight (states RUN and FIX).
- done  output  1  one-cycle pulse after HI/LO are updated by an operation.
- hi  output  32  HI register (multiply upper word / remainder).
- lo  output  32  LO register (multiply lower word / quotient).

## Operation
- States:
  - IDLE: `start`=1 latches op and operands, sets the 5-bit counter to 0, goes to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After 32 iterations (counter 31 → wrap) goes to FIX.
  - FIX: applies sign correction, writes HI/LO, goes to IDLE and asserts `done`.
- Signed ops: operands are converted to magnitudes on accept.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply: the 64-bit product splits into HI = [63:32] and LO = [31:0]; no overflow is possible.
- Divide by zero: not trapped, full latency.
  - divu: LO = 0xFFFFFFFF, HI = operand_a.
  - div: LO = 0xFFFFFFFF if operand_a ≥ 0, else 0x00000001; HI = operand_a.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; no trap.
- `start` while busy is ignored and not queued.
- `hi_write` / `lo_write`:
  - Take effect on the edge when state is IDLE; both may be asserted together.
  - Ignored while busy.
  - If `start` and `hi_write`/`lo_write` arrive on the same IDLE edge, the write lands first and is overwritten by the operation's result at FIX.
- HI/LO hold their value at all other times. Intermediate state is kept in internal registers, so `hi`/`lo` never show partial results.

## Timing
- Accepting edge E0: `busy` is 1 from just after E0.
- RUN covers edges E1..E32; FIX executes on edge E33.
- After E33: `hi`/`lo` are valid, `busy` = 0, `done` = 1 for exactly one cycle (cleared at E34).
- A new `start` may be accepted at E34 at the earliest, i.e. while `done` is high. Issue rate is 1 operation per 34 cycles.
- Reset values: state IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0.
- Reset asserted mid-operation aborts it: no HI/LO update and no `done` pulse.
- Reset has priority over `start`, `hi_write` and `lo_write` on the same edge.

## Configuration
- `MULDIV_SIGNED_EN` defined: op codes 01 and 11 perform signed mult/div as above.
- Undefined: op[0] is ignored, all operations are unsigned, and the sign-fix logic is removed. FIX still takes one cycle, so latency is unchanged.

## Test plan
- Reset, then idle: hi = 0, lo = 0, busy = 0, done = 0.
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - HI = 0xFFFFFFFE, LO = 0x00000001.
  - `done` high in exactly the cycle after E33; busy for 33 cycles.
- mult 0xFFFFFFFD × 0x00000007 (-3 × 7): HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- div 0xFFFFFFF9 / 0x00000002 (-7 / 2):
  - LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Without `MULDIV_SIGNED_EN`: unsigned result, LO = 0x7FFFFFFC, HI = 0x00000001.
- divu 0x00000064 / 0: LO = 0xFFFFFFFF, HI = 0x00000064.
- Handshake and reset checks:
  - `start` and `hi_write` (0x1234) pulsed at edge E5 of a running op: no effect, result unchanged.
  - Reset at E10: hi = lo = 0, no `done` pulse.
  - mthi 0xCAFEF00D in IDLE: HI = 0xCAFEF00D next cycle.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 33-cycle multiply/divide unit owning the HI/LO registers.
// Define MULDIV_SIGNED_EN to enable signed mult/div (op[0] = 1).
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic        is_div;
  logic [31:0] divisor;
  logic [63:0] acc;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] div_step;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

`ifdef MULDIV_SIGNED_EN
  logic        sign_a;
  logic        sign_b;
  logic        neg_q;
  logic        neg_r;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sign_a = op[0] & operand_a[31];
  assign sign_b = op[0] & operand_b[31];
  assign mag_a  = sign_a ? (~operand_a + 32'd1)
                         : operand_a;
  assign mag_b  = sign_b ? (~operand_b + 32'd1)
                         : operand_b;

  always_comb begin
    prod   = neg_q ? (~acc + 64'd1) : acc;
    quo    = neg_q ? (~acc[31:0] + 32'd1)
                   : acc[31:0];
    rem    = neg_r ? (~acc[63:32] + 32'd1)
                   : acc[63:32];
    fix_hi = is_div ? rem : prod[63:32];
    fix_lo = is_div ? quo : prod[31:0];
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign mag_a      = operand_a;
  assign mag_b      = operand_b;
  assign fix_hi     = acc[63:32];
  assign fix_lo     = acc[31:0];
`endif

  // Multiply: right-shifting shift-add, multiplier in acc[31:0].
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]}
             + ({33{acc[0]}} & {1'b0, divisor});
    mul_step = {mul_sum, acc[31:1]};
  end

  // Divide: restoring, {remainder, quotient} shifted left in acc.
  always_comb begin
    rem_sh = acc[63:31];
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[32]) begin
      div_step = {trial[31:0], acc[30:0], 1'b1};
    end else begin
      div_step = {rem_sh[31:0], acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == 5'd31) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      count   <= 5'd0;
      acc     <= 64'd0;
      divisor <= 32'd0;
      is_div  <= 1'b0;
      done    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (hi_write) begin
            hi <= write_data;
          end
          if (lo_write) begin
            lo <= write_data;
          end
          if (start) begin
            count  <= 5'd0;
            is_div <= op[1];
            if (op[1]) begin
              acc     <= {32'd0, mag_a};
              divisor <= mag_b;
            end else begin
              acc     <= {32'd0, mag_b};
              divisor <= mag_a;
            end
`ifdef MULDIV_SIGNED_EN
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
`endif
          end
        end
        RUN: begin
          acc   <= is_div ? div_step : mul_step;
          count <= count + 5'd1;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus
// handshake/reset sequences, results checked through a scoreboard.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got 1 want 0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
      end
    end
  end

  task automatic issue(input logic [1:0]  o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] ehi,
                       input logic [31:0] elo,
                       input bit          push);
    exp_t e;
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      sb_q.push_back(e);
    end
    @(negedge clock);
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_after_accept", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(input int exp_busy);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy) n++;
      @(negedge clock);
    end
    if (done !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL done_timeout: got 0 want 1");
    end
    check("busy_cycles", n, exp_busy);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int seen;
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'h0000_FFFF, 32'h0000_FFFF,
                32'h0000_0000, 32'hFFFE_0001};
    vecs[2] = '{2'b10, 32'h0000_0064, 32'h0000_0000,
                32'h0000_0064, 32'hFFFF_FFFF};
    vecs[3] = '{2'b10, 32'h0000_0064, 32'h0000_0007,
                32'h0000_0002, 32'h0000_000E};
    vecs[4] = '{2'b00, 32'h0001_0000, 32'h0001_0000,
                32'h0000_0001, 32'h0000_0000};
`ifdef MULDIV_SIGNED_EN
    vecs[5] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007,
                32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
                32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0000_0000, 32'h8000_0000};
    vecs[8] = '{2'b11, 32'hFFFF_FF9C, 32'h0000_0000,
                32'hFFFF_FF9C, 32'h0000_0001};
    vecs[9] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE,
                32'h0000_0001, 32'hFFFF_FFFD};
`else
    vecs[5] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007,
                32'h0000_0006, 32'hFFFF_FFEB};
    vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
                32'h0000_0001, 32'h7FFF_FFFC};
    vecs[7] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'h0000_0000};
    vecs[8] = '{2'b11, 32'hFFFF_FF9C, 32'h0000_0000,
                32'hFFFF_FF9C, 32'hFFFF_FFFF};
    vecs[9] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE,
                32'h0000_0007, 32'h0000_0000};
`endif

    reset      = 1'b1;
    start      = 1'b0;
    op         = 2'b00;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    write_data = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    hi_write   = 1'b1;
    write_data = 32'hCAFE_F00D;
    @(negedge clock);
    hi_write = 1'b0;
    check("mthi_hi", hi, 32'hCAFE_F00D);
    check("mthi_lo", lo, 32'd0);
    lo_write   = 1'b1;
    write_data = 32'h5555_AAAA;
    @(negedge clock);
    lo_write = 1'b0;
    check("mtlo_lo", lo, 32'h5555_AAAA);
    check("mtlo_hi", hi, 32'hCAFE_F00D);

    // Each new op is issued while done is still high.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, 1'b1);
      wait_done(33);
    end
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    lo_write   = 1'b1;
    write_data = 32'h0BAD_BEEF;
    issue(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    check("write_with_start_lo", lo, 32'h0BAD_BEEF);
    wait_done(33);

    issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (4) @(negedge clock);
    start      = 1'b1;
    op         = 2'b00;
    operand_a  = 32'h1234;
    operand_b  = 32'h1234;
    hi_write   = 1'b1;
    write_data = 32'h1234;
    @(negedge clock);
    start    = 1'b0;
    hi_write = 1'b0;
    check("busy_write_ignored_hi", hi, 32'd0);
    wait_done(28);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_hi_held", hi, 32'd0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
